// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_arbiter_rr_pick8.sv
// Combinational rotate-priority picker: first set request at or after ptr, modulo 8.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select, with a one-cycle dead gap between owners.
// Optional grant timeout is compiled in with MUX8_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no owner; grant the next requester found from ptr
//   GRANT | owner holds the mux; Sel/Grant frozen
//   GAP   | one dead cycle after a grant ends, then IDLE
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               Release,
  output logic [SEL_W-1:0]   Sel,
  output logic [NUM_REQ-1:0] Grant,
  output logic               Busy,
  output logic               TimedOut
);

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  arb_state_t         state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n, owner, owner_n, sel_n;
  logic [7:0]         cnt, cnt_n;
  logic [NUM_REQ-1:0] grant_n;
  logic               busy_n, timed_out_n;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               timeout_hit, grant_end;

  rr_pick8 u_pick (
    .req (Req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign timeout_hit = TIMEOUT_EN && (cnt == 8'(HOLD_MAX));
  assign grant_end   = Release || !Req[owner] || timeout_hit;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    owner_n     = owner;
    cnt_n       = cnt;
    sel_n       = Sel;
    grant_n     = Grant;
    busy_n      = Busy;
    timed_out_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          owner_n = pick_idx;
          sel_n   = pick_idx;
          grant_n = onehot8(pick_idx);
          busy_n  = 1'b1;
          cnt_n   = 8'd1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (grant_end) begin
          grant_n     = '0;
          busy_n      = 1'b0;
          ptr_n       = owner + SEL_W'(1);
          state_n     = GAP;
          // Release or withdrawal takes precedence over a coincident timeout
          timed_out_n = timeout_hit && !Release && Req[owner];
        end else if (cnt != 8'hFF) begin
          cnt_n = cnt + 8'd1;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      Sel      <= '0;
      Grant    <= '0;
      Busy     <= 1'b0;
      TimedOut <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      cnt      <= cnt_n;
      Sel      <= sel_n;
      Grant    <= grant_n;
      Busy     <= busy_n;
      TimedOut <= timed_out_n;
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed scoreboard bench for mux8_arbiter (HOLD_MAX=4); covers timeout when MUX8_ARB_TIMEOUT_EN is set.
module tb_mux8_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Req;
  logic       Release;
  logic [2:0] Sel;
  logic [7:0] Grant;
  logic       Busy;
  logic       TimedOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb[$];

  mux8_arbiter #(.HOLD_MAX(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Req      (Req),
    .Release  (Release),
    .Sel      (Sel),
    .Grant    (Grant),
    .Busy     (Busy),
    .TimedOut (TimedOut)
  );

  always #5 Clock = ~Clock;

  // Push the expected post-edge outputs, advance one edge, then pop and compare.
  task automatic step(input string tag, input logic [2:0] sel, input logic [7:0] grant,
                      input logic busy, input logic to);
    exp_t e, x;
    logic [12:0] got, want;
    e.tag = tag; e.sel = sel; e.grant = grant; e.busy = busy; e.to = to;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      x    = sb.pop_front();
      got  = {Sel, Grant, Busy, TimedOut};
      want = {x.sel, x.grant, x.busy, x.to};
      assert (got === want) else begin
        errors++;
        $error("FAIL %s: observed sel=%0d grant=%02h busy=%b to=%b, expected sel=%0d grant=%02h busy=%b to=%b",
               x.tag, Sel, Grant, Busy, TimedOut, x.sel, x.grant, x.busy, x.to);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Req = 8'h00; Release = 1'b0;
    step("reset", 3'd0, 8'h00, 1'b0, 1'b0);
    Reset = 1'b0;

    Req = 8'b0000_0100;
    step("grant2", 3'd2, 8'h04, 1'b1, 1'b0);
    Release = 1'b1;
    step("release2", 3'd2, 8'h00, 1'b0, 1'b0);
    Release = 1'b0; Req = 8'h00;
    step("gap2", 3'd2, 8'h00, 1'b0, 1'b0);

    // ptr is now 3: search from 3 must wrap to index 0
    Req = 8'b0000_0011;
    step("wrap_grant0", 3'd0, 8'h01, 1'b1, 1'b0);
    Release = 1'b1;
    step("wrap_rel0", 3'd0, 8'h00, 1'b0, 1'b0);
    Release = 1'b0; Req = 8'h00;
    step("wrap_gap0", 3'd0, 8'h00, 1'b0, 1'b0);

    // Continuous requests, 1-cycle holds: one grant every 3 edges, owners rotate from ptr=1
    Req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] o;
      o = 3'((1 + k) % 8);
      Release = 1'b0;
      step($sformatf("rr_grant%0d", k), o, 8'(1) << o, 1'b1, 1'b0);
      Release = 1'b1;
      step($sformatf("rr_rel%0d", k), o, 8'h00, 1'b0, 1'b0);
      Release = 1'b0;
      if (k == 8) Req = 8'h00;
      step($sformatf("rr_gap%0d", k), o, 8'h00, 1'b0, 1'b0);
    end

    // ptr=2: owner 6 withdraws without Release; next search starts at 7
    Req = 8'h40;
    step("wd_grant6", 3'd6, 8'h40, 1'b1, 1'b0);
    Req = 8'h83;
    step("wd_end6", 3'd6, 8'h00, 1'b0, 1'b0);
    step("wd_gap6", 3'd6, 8'h00, 1'b0, 1'b0);
    step("wd_grant7", 3'd7, 8'h80, 1'b1, 1'b0);
    Release = 1'b1;
    step("wd_rel7", 3'd7, 8'h00, 1'b0, 1'b0);
    Release = 1'b0; Req = 8'h00;
    step("wd_gap7", 3'd7, 8'h00, 1'b0, 1'b0);
    Release = 1'b1;
    step("idle_release", 3'd7, 8'h00, 1'b0, 1'b0);
    Release = 1'b0;

    // ptr=0: hold requester 5 with no Release
    Req = 8'h20;
    step("hold_grant5", 3'd5, 8'h20, 1'b1, 1'b0);
`ifdef MUX8_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) step($sformatf("hold5_%0d", k), 3'd5, 8'h20, 1'b1, 1'b0);
    step("timeout5", 3'd5, 8'h00, 1'b0, 1'b1);
    Req = 8'h00;
    step("timeout_gap5", 3'd5, 8'h00, 1'b0, 1'b0);
`else
    for (int k = 0; k < 20; k++) step($sformatf("hold5_%0d", k), 3'd5, 8'h20, 1'b1, 1'b0);
    Release = 1'b1;
    step("hold_rel5", 3'd5, 8'h00, 1'b0, 1'b0);
    Release = 1'b0; Req = 8'h00;
    step("hold_gap5", 3'd5, 8'h00, 1'b0, 1'b0);
`endif

    // ptr=6: grant 5 again, then reset mid-grant
    Req = 8'h20;
    step("pre_reset5", 3'd5, 8'h20, 1'b1, 1'b0);
    step("pre_reset5b", 3'd5, 8'h20, 1'b1, 1'b0);
    Reset = 1'b1;
    step("mid_reset", 3'd0, 8'h00, 1'b0, 1'b0);
    Reset = 1'b0; Req = 8'h30;
    step("post_reset4", 3'd4, 8'h10, 1'b1, 1'b0);

    // Release arriving on the same edge the timeout would fire: no TimedOut
    for (int k = 0; k < 3; k++) step($sformatf("hold4_%0d", k), 3'd4, 8'h10, 1'b1, 1'b0);
    Release = 1'b1;
    step("rel_vs_timeout", 3'd4, 8'h00, 1'b0, 1'b0);
    Release = 1'b0; Req = 8'h00;
    step("final_gap", 3'd4, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
